// File: rtl/raisin64_uart_tx.sv
// raisin64_uart_tx
//   Memory-mapped 8N1 UART transmitter for the raisin64 IO space. The CPU
//   pushes bytes into a TX FIFO through the DATA register. A baud-rate state
//   machine drains the FIFO onto `tx`. The STATUS register reports FIFO level,
//   busy, a sticky overflow flag, empty and full.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   sel          UART region decode
//   addr_valid   bus address valid
//   addr3        mem_addr[3]: 0 = DATA (0x0), 1 = STATUS (0x8)
//   write        bus write strobe
//   din[63:0]    write data
//   dout[63:0]   read data, zero unless a read is in progress (OR-muxable)
//   ready        single-cycle access acknowledge
//   tx           serial output, idle high
module raisin64_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        addr_valid,
  input  logic        addr3,
  input  logic        write,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        ready,
  output logic        tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic acc;
  logic push_req;
  logic ovf_clr;
  logic push;
  logic pop;

  // Registered state
  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            full;
  logic            empty;
  logic            busy;
  logic [8:0]      count_ext;
  logic [7:0]      count_field;

  // Only din[7:0] and din[2] carry meaning; the rest of the bus is ignored.
  logic            din_unused;
  assign din_unused = ^din[63:8];

  assign acc      = sel & addr_valid;
  assign ready    = acc;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign push_req = acc & write & ~addr3;
  assign ovf_clr  = acc & write & addr3 & din[2];
  // Full is judged on the start-of-cycle count, so a same-cycle pop never
  // makes room for the write.
  assign push     = push_req & ~full;
  assign tx       = tx_q;

  // A depth-256 FIFO can hold 256 entries, which does not fit the 8-bit field.
  assign count_ext   = 9'(count_q);
  assign count_field = count_ext[8] ? 8'hFF : count_ext[7:0];

  always_comb begin
    dout = '0;
    if (acc && !write && addr3) begin
      dout = {48'h0, count_field, 4'h0, busy, ovf_q, empty, full};
    end
  end

  // TX state machine: next state, baud timing and shift register
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            // Next bit is shift_q[1]: the value after this cycle's shift.
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A rejected push and a clear in the same cycle resolve to set.
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din[7:0];
    end
  end

endmodule

// File: tb/tb_raisin64_uart_tx.sv
module tb_raisin64_uart_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        addr_valid;
  logic        addr3;
  logic        write;
  logic [63:0] din;
  logic [63:0] dout;
  logic        ready;
  logic        tx;

  int checks = 0;
  int errors = 0;

  raisin64_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .addr_valid (addr_valid),
    .addr3      (addr3),
    .write      (write),
    .din        (din),
    .dout       (dout),
    .ready      (ready),
    .tx         (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: FIFO as a queue, line position as an index into the
  // current 10-bit frame (-1 while the line is idle between frames).
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;

  function automatic logic m_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / CD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [63:0] m_dout();
    logic [7:0] cnt;
    cnt = 8'(m_q.size());
    if (sel && addr_valid && !write && addr3)
      return {48'h0, cnt, 4'h0, (m_pos >= 0), m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH)};
    return 64'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit m_acc, m_full, m_preq, m_clr;
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_pos = -1;
      m_cur = 8'h00;
    end else begin
      m_acc  = sel && addr_valid;
      m_full = (m_q.size() == DEPTH);
      m_preq = m_acc && write && !addr3;
      m_clr  = m_acc && write && addr3 && din[2];
      if (m_pos < 0) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end
      end else begin
        m_pos = m_pos + 1;
        if (m_pos == 10 * CD) m_pos = -1;
      end
      if (m_preq && !m_full) m_q.push_back(din[7:0]);
      if (m_preq && m_full) m_ovf = 1'b1;
      else if (m_clr) m_ovf = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("tx", {63'h0, tx}, {63'h0, m_tx()});
    chk("ready", {63'h0, ready}, {63'h0, (sel && addr_valid)});
    chk("dout", dout, m_dout());
  end

  task automatic set_idle();
    sel = 1'b0; addr_valid = 1'b0; addr3 = 1'b0; write = 1'b0; din = 64'h0;
  endtask

  // One single-cycle bus access, entered and left at 1 time unit after an edge.
  task automatic bus(input logic s, input logic v, input logic a, input logic w,
                     input logic [63:0] d);
    sel = s; addr_valid = v; addr3 = a; write = w; din = d;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic status_expect(input logic [63:0] exp, input string name);
    sel = 1'b1; addr_valid = 1'b1; addr3 = 1'b1; write = 1'b0; din = 64'h0;
    #1;
    chk(name, dout, exp);
    chk({name, "_ready"}, {63'h0, ready}, 64'h1);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic samples [40];

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("reset_tx", {63'h0, tx}, 64'h1);
    status_expect(64'h2, "reset_status");

    // Single frame 0xA5: start, LSB-first data, stop
    bus(1, 1, 0, 1, 64'hFFFF_0000_0000_00A5);
    chk("a5_tx_n1", {63'h0, tx}, 64'h1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      samples[i] = tx;
    end
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("a5_bit%0d_c%0d", i / CD, i % CD), {63'h0, samples[i]}, {63'h0, exp_bits[i / CD]});
    end
    @(posedge clk); #1;
    status_expect(64'h2, "a5_done_status");

    // Fill FIFO, overflow, clear
    for (int i = 1; i <= 5; i++) bus(1, 1, 0, 1, 64'(i));
    status_expect(64'h409, "fill_status");
    bus(1, 1, 0, 1, 64'h6);
    status_expect(64'h40D, "ovf_status");
    bus(1, 1, 1, 1, 64'h0);
    status_expect(64'h40D, "ovf_keep_status");
    bus(1, 1, 1, 1, 64'h4);
    status_expect(64'h409, "ovf_clear_status");
    idle_cycles(5 * (10 * CD + 1) + 10);
    status_expect(64'h2, "drained_status");

    // Unselected write: no push, no ack, zero data
    sel = 1'b0; addr_valid = 1'b1; addr3 = 1'b0; write = 1'b1; din = 64'hEE;
    #1;
    chk("unsel_ready", {63'h0, ready}, 64'h0);
    chk("unsel_dout", dout, 64'h0);
    @(posedge clk); #1;
    set_idle();
    status_expect(64'h2, "unsel_status");

    // Reset in the middle of a data bit
    bus(1, 1, 0, 1, 64'h3C);
    repeat (10) @(posedge clk);
    #3;
    chk("pre_reset_tx", {63'h0, tx}, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", {63'h0, tx}, 64'h1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    status_expect(64'h2, "post_reset_status");
    idle_cycles(50);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       bus(1, 1, 0, 1, {$urandom, $urandom});
      else if (r < 14) bus(1, 1, 1, 1, {$urandom, $urandom});
      else if (r < 30) bus(1, 1, 1, 0, {$urandom, $urandom});
      else if (r < 35) bus(1, 1, 0, 0, {$urandom, $urandom});
      else if (r < 40) bus(0, 1, 0, 1, {$urandom, $urandom});
      else if (r < 45) bus(1, 0, 0, 1, {$urandom, $urandom});
      else             bus(0, 0, r[0], r[1], {$urandom, $urandom});
    end
    idle_cycles(DEPTH * (10 * CD + 1) + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raisin64_uart_tx.md
# raisin64_uart_tx

Memory-mapped UART transmitter on the raisin64 external memory bus, alongside the LED and switch registers in IO space. The CPU writes bytes into a TX FIFO; a baud-rate state machine serializes them as 8N1 frames on `tx`. A status register exposes FIFO level and flags. Reads return through a zero-when-unselected data path, so the result can be OR-muxed into `mem_din`.

## Interface
- `CLK_DIV`, 868: clock cycles per bit, ≥2 (100 MHz / 115200).
- `FIFO_DEPTH`, 16: TX FIFO entries, power of two, 2–256.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sel` in 1: UART region decode from the memory map.
- `addr_valid` in 1: bus address valid.
- `addr3` in 1: `mem_addr[3]`. 0 = DATA (offset 0x0), 1 = STATUS (offset 0x8).
- `write` in 1: bus write strobe.
- `din` in 64: write data from CPU.
- `dout` out 64: read data. All zeros when not accessed.
- `ready` out 1: access acknowledge.
- `tx` out 1: serial output, idle high.

## Operation
- Access: `acc = sel & addr_valid`. Only 64-bit aligned accesses are supported. Each cycle with `acc` high counts as one access.
- `ready = acc`, combinational, so every access completes in a single cycle.
- DATA write (`acc & write & ~addr3`):
  - If the FIFO is not full, push `din[7:0]`.
  - If the FIFO is full, drop the byte and set sticky `ovf`.
  - Full is evaluated before any same-cycle pop, so a push to a full FIFO is rejected even if a pop occurs in that cycle.
- STATUS write (`acc & write & addr3`): `din[2]=1` clears `ovf`. All other bits are ignored. If an overflow and a clear happen in the same cycle, the set wins.
- Read (`acc & ~write`), combinational:
  - DATA reads return 0.
  - STATUS reads return {48'h0, count[7:0], 4'h0, busy, ovf, empty, full}.
  - `count` is the FIFO occupancy (0..FIFO_DEPTH). At depth 256 it saturates the field as 8'hFF.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH). Pointers wrap modulo the depth. A separate occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- TX FSM states: IDLE, START, DATA, STOP. `tx` is registered.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the 8-bit shift register, load the baud counter with CLK_DIV-1, and go to START.
  - START: `tx`=0 for CLK_DIV cycles. Then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLK_DIV cycles per bit, LSB first, shifting right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles, then go to IDLE.
- `busy` = FSM state != IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty.

## Timing
- Reset values: `tx`=1, FSM=IDLE, pointers=0, count=0, `ovf`=0, shift=0, baud counter=0. `dout`/`ready` are 0 because they are combinational from the idle bus.
- Reset asserted mid-frame forces `tx` high immediately (asynchronously). FIFO contents are discarded.
- Write latency: DATA write in cycle N → FIFO non-empty at N+1 → FSM pops at N+1 → `tx` falls at the first edge after N+1, i.e. observable low in cycle N+2.
- Frame length: 10×CLK_DIV cycles from start edge to the end of the stop bit, plus 1 IDLE cycle before the next start.
- STATUS reflects register state at the start of the cycle. A push in cycle N shows in `count` from N+1.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- Empty: the FSM stays in IDLE and never pops. Full: `full`=1 when count==FIFO_DEPTH.

## Test plan
- Reset (CLK_DIV=4, FIFO_DEPTH=4) → `tx`=1, STATUS read returns 0x2 (empty), `ready`=1 during the access.
- Write 0xA5 to DATA → `tx` low from N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; `busy`=1 throughout the frame, then 0.
- Write 5 bytes 0x01..0x05 back-to-back while the FSM is in IDLE → first byte popped at N+1, so bytes 2–5 fill the FIFO (STATUS full=1, count=4); a 6th write sets `ovf` (STATUS bit2=1), all 5 accepted bytes are transmitted in order, and the 6th is dropped.
- STATUS write 0x4 → `ovf` clears. STATUS write 0x0 → `ovf` unchanged.
- Drop `rst_n` mid-DATA bit → `tx`=1 immediately, STATUS=0x2 after release, no residual frame.
- `sel`=0 with `addr_valid`=1 and `write`=1 → no push, `dout`=0, `ready`=0.
